// File: rtl/spi_slave_endpoint_if.sv
// Pin-level and byte-stream signals of the SPI slave endpoint.
// The slave modport is the endpoint's view; master is the driving side (bench or SoC glue).
interface spi_slave_endpoint_if;
  logic       cpol;
  logic       cpha;
  logic       lsbfe;
  logic       sclk;
  logic       ss;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_overrun;
  logic       tx_underrun;

  modport slave (
    input  cpol, cpha, lsbfe, sclk, ss, mosi, tx_data, tx_valid, rx_ready,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, rx_overrun, tx_underrun
  );

  modport master (
    output cpol, cpha, lsbfe, sclk, ss, mosi, tx_data, tx_valid, rx_ready,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, rx_overrun, tx_underrun
  );
endinterface

// File: rtl/spi_slave_endpoint.sv
// SPI slave endpoint: oversamples sclk/ss/mosi in the PCLK domain, deserialises
// received bytes onto a valid/ready port and serialises bytes from a one-entry tx buffer.
module spi_slave_endpoint #(
  parameter logic [7:0] TX_DEFAULT = 8'hFF
) (
  input logic PCLK,
  input logic PRESETn,
  spi_slave_endpoint_if.slave bus
);

  logic sclk_m_q, sclk_s_q, sclk_p_q;
  logic ss_m_q, ss_s_q, ss_p_q;
  logic mosi_m_q, mosi_s_q;

  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] tx_sr_q, tx_sr_d;
  logic [7:0] rx_sr_q, rx_sr_d;
  logic [7:0] tx_buf_q, tx_buf_d;
  logic       tx_full_q, tx_full_d;
  logic       from_buf_q, from_buf_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_overrun_q, rx_overrun_d;
  logic       tx_underrun_q, tx_underrun_d;
  logic       miso_q, miso_d;
  logic       miso_oe_q, miso_oe_d;

  logic       active, sclk_rise, sclk_fall, lead_ev, trail_ev;
  logic       sample_ev, shift_ev, ss_fall, ss_rise, load_ev;
  logic [7:0] rx_shift;

  // ss resets deasserted so the sclk flop's cpol-independent reset value cannot fake an edge
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      sclk_m_q <= 1'b0;
      sclk_s_q <= 1'b0;
      sclk_p_q <= 1'b0;
      ss_m_q   <= 1'b1;
      ss_s_q   <= 1'b1;
      ss_p_q   <= 1'b1;
      mosi_m_q <= 1'b0;
      mosi_s_q <= 1'b0;
    end else begin
      sclk_m_q <= bus.sclk;
      sclk_s_q <= sclk_m_q;
      sclk_p_q <= sclk_s_q;
      ss_m_q   <= bus.ss;
      ss_s_q   <= ss_m_q;
      ss_p_q   <= ss_s_q;
      mosi_m_q <= bus.mosi;
      mosi_s_q <= mosi_m_q;
    end
  end

  always_comb begin
    active    = !ss_s_q;
    sclk_rise = sclk_s_q & ~sclk_p_q;
    sclk_fall = ~sclk_s_q & sclk_p_q;
    lead_ev   = bus.cpol ? sclk_fall : sclk_rise;
    trail_ev  = bus.cpol ? sclk_rise : sclk_fall;
    sample_ev = active & (bus.cpha ? trail_ev : lead_ev);
    shift_ev  = active & (bus.cpha ? lead_ev : trail_ev);
    ss_fall   = ss_p_q & ~ss_s_q;
    ss_rise   = ~ss_p_q & ss_s_q;
    load_ev   = (ss_fall & ~bus.cpha) | (shift_ev & (bit_cnt_q == 3'd0));
    rx_shift  = bus.lsbfe ? {mosi_s_q, rx_sr_q[7:1]} : {rx_sr_q[6:0], mosi_s_q};
  end

  always_comb begin
    bit_cnt_d     = bit_cnt_q;
    tx_sr_d       = tx_sr_q;
    rx_sr_d       = rx_sr_q;
    tx_buf_d      = tx_buf_q;
    tx_full_d     = tx_full_q;
    from_buf_d    = from_buf_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    rx_overrun_d  = 1'b0;
    tx_underrun_d = 1'b0;
    miso_d        = active & (bus.lsbfe ? tx_sr_q[0] : tx_sr_q[7]);
    miso_oe_d     = active;

    if (bus.tx_valid && !tx_full_q) begin
      tx_buf_d  = bus.tx_data;
      tx_full_d = 1'b1;
    end

    if (rx_valid_q && bus.rx_ready)
      rx_valid_d = 1'b0;

    if (ss_rise) begin
      bit_cnt_d = 3'd0;
      tx_sr_d   = 8'h00;
      rx_sr_d   = 8'h00;
    end else begin
      if (load_ev) begin
        tx_sr_d       = tx_full_q ? tx_buf_q : TX_DEFAULT;
        from_buf_d    = tx_full_q;
        tx_underrun_d = !tx_full_q;
      end else if (shift_ev) begin
        tx_sr_d = bus.lsbfe ? {1'b0, tx_sr_q[7:1]} : {tx_sr_q[6:0], 1'b0};
      end

      if (sample_ev) begin
        rx_sr_d   = rx_shift;
        bit_cnt_d = bit_cnt_q + 3'd1;
        // the buffer is only consumed once its byte is really on the wire
        if (bit_cnt_q == 3'd0 && from_buf_q)
          tx_full_d = 1'b0;
        if (bit_cnt_q == 3'd7) begin
          rx_data_d    = rx_shift;
          rx_valid_d   = 1'b1;
          rx_overrun_d = rx_valid_q & ~bus.rx_ready;
        end
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      bit_cnt_q     <= 3'd0;
      tx_sr_q       <= 8'h00;
      rx_sr_q       <= 8'h00;
      tx_buf_q      <= 8'h00;
      tx_full_q     <= 1'b0;
      from_buf_q    <= 1'b0;
      rx_data_q     <= 8'h00;
      rx_valid_q    <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
      miso_q        <= 1'b0;
      miso_oe_q     <= 1'b0;
    end else begin
      bit_cnt_q     <= bit_cnt_d;
      tx_sr_q       <= tx_sr_d;
      rx_sr_q       <= rx_sr_d;
      tx_buf_q      <= tx_buf_d;
      tx_full_q     <= tx_full_d;
      from_buf_q    <= from_buf_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_underrun_q <= tx_underrun_d;
      miso_q        <= miso_d;
      miso_oe_q     <= miso_oe_d;
    end
  end

  assign bus.miso        = miso_q;
  assign bus.miso_oe     = miso_oe_q;
  assign bus.tx_ready    = !tx_full_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.rx_overrun  = rx_overrun_q;
  assign bus.tx_underrun = tx_underrun_q;

endmodule

// File: tb/tb_spi_slave_endpoint.sv
// Directed bench for spi_slave_endpoint: a behavioural SPI master drives the pins,
// expected rx bytes and expected miso bytes are queued and compared as the DUT produces them.
module tb_spi_slave_endpoint;
  localparam int HP = 5;

  logic PCLK;
  logic PRESETn;

  spi_slave_endpoint_if bus();

  spi_slave_endpoint #(.TX_DEFAULT(8'hFF)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  int und_cnt = 0;
  int ovr_cnt = 0;
  logic [7:0] rx_exp[$];
  logic [7:0] miso_exp[$];

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  always @(negedge PCLK) begin
    if (bus.tx_underrun === 1'b1) und_cnt++;
    if (bus.rx_overrun === 1'b1) ovr_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_mode(input logic p, input logic a, input logic l);
    @(negedge PCLK);
    bus.cpol  = p;
    bus.cpha  = a;
    bus.lsbfe = l;
    bus.sclk  = p;
    repeat (HP) @(negedge PCLK);
  endtask

  task automatic start_xfer();
    @(negedge PCLK);
    bus.ss = 1'b0;
  endtask

  task automatic end_xfer();
    repeat (HP) @(negedge PCLK);
    bus.ss = 1'b1;
    repeat (2 * HP) @(negedge PCLK);
  endtask

  task automatic preload(input logic [7:0] d);
    @(negedge PCLK);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(negedge PCLK);
    bus.tx_valid = 1'b0;
    chk1("tx_ready_after_load", bus.tx_ready, 1'b0);
  endtask

  // Called at the negedge where the final sample edge hits the pin; pulses rx_ready
  // exactly in the cycle the synchronised edge completes the byte.
  task automatic acc_window();
    logic [7:0] e;
    @(posedge PCLK);
    @(posedge PCLK);
    @(negedge PCLK);
    chk1("acc_prev_valid", bus.rx_valid, 1'b1);
    e = rx_exp.pop_front();
    chk8("acc_prev_data", bus.rx_data, e);
    bus.rx_ready = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    bus.rx_ready = 1'b0;
  endtask

  task automatic spi_xfer(input logic [7:0] mo, input int nbits, input bit acc_last,
                          output logic [7:0] mi);
    logic [2:0] idx;
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      idx = bus.lsbfe ? i[2:0] : 3'(7 - i);
      if (!bus.cpha) begin
        bus.mosi = mo[idx];
        repeat (HP) @(negedge PCLK);
        bus.sclk = ~bus.cpol;
        mi[idx] = bus.miso;
        if (acc_last && i == 7) begin
          acc_window();
          repeat (HP - 3) @(negedge PCLK);
        end else begin
          repeat (HP) @(negedge PCLK);
        end
        bus.sclk = bus.cpol;
      end else begin
        repeat (HP) @(negedge PCLK);
        bus.sclk = ~bus.cpol;
        bus.mosi = mo[idx];
        repeat (HP) @(negedge PCLK);
        bus.sclk = bus.cpol;
        mi[idx] = bus.miso;
        if (acc_last && i == 7) acc_window();
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] mo, input logic [7:0] exp_mi, input bit acc_last);
    logic [7:0] mi;
    logic [7:0] e;
    rx_exp.push_back(mo);
    miso_exp.push_back(exp_mi);
    spi_xfer(mo, 8, acc_last, mi);
    e = miso_exp.pop_front();
    chk8("master_rx_byte", mi, e);
  endtask

  task automatic read_rx();
    logic [7:0] e;
    if (rx_exp.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL rx_scoreboard: observed rx_data %h with no expected byte queued", bus.rx_data);
    end else begin
      e = rx_exp.pop_front();
      chk1("rx_valid_held", bus.rx_valid, 1'b1);
      chk8("rx_data", bus.rx_data, e);
      @(negedge PCLK);
      bus.rx_ready = 1'b1;
      @(negedge PCLK);
      bus.rx_ready = 1'b0;
      chk1("rx_valid_clear", bus.rx_valid, 1'b0);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, "_miso"}, bus.miso, 1'b0);
    chk1({tag, "_miso_oe"}, bus.miso_oe, 1'b0);
    chk1({tag, "_tx_ready"}, bus.tx_ready, 1'b1);
    chk8({tag, "_rx_data"}, bus.rx_data, 8'h00);
    chk1({tag, "_rx_valid"}, bus.rx_valid, 1'b0);
    chk1({tag, "_rx_overrun"}, bus.rx_overrun, 1'b0);
    chk1({tag, "_tx_underrun"}, bus.tx_underrun, 1'b0);
  endtask

  initial begin
    int u0;
    int o0;
    logic [1:0] mm;
    logic [7:0] mi;

    PRESETn      = 1'b0;
    bus.cpol     = 1'b0;
    bus.cpha     = 1'b0;
    bus.lsbfe    = 1'b0;
    bus.sclk     = 1'b0;
    bus.ss       = 1'b1;
    bus.mosi     = 1'b0;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    bus.rx_ready = 1'b0;
    repeat (3) @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    chk_reset_outputs("reset");

    // Mode 0 receive, empty tx buffer
    set_mode(1'b0, 1'b0, 1'b0);
    start_xfer();
    u0 = und_cnt;
    send_byte(8'hA5, 8'hFF, 1'b0);
    chk_int("mode0_underrun_once", und_cnt - u0, 1);
    end_xfer();
    read_rx();

    // All four modes, LSB first, preloaded tx byte
    for (int m = 0; m < 4; m++) begin
      mm = m[1:0];
      set_mode(mm[1], mm[0], 1'b1);
      preload(8'h3C);
      start_xfer();
      send_byte(8'hC3, 8'h3C, 1'b0);
      end_xfer();
      chk1("tx_ready_after_xfer", bus.tx_ready, 1'b1);
      read_rx();
    end

    // Back-to-back bytes with rx_ready held low
    set_mode(1'b0, 1'b1, 1'b0);
    start_xfer();
    o0 = ovr_cnt;
    send_byte(8'h01, 8'hFF, 1'b0);
    send_byte(8'h02, 8'hFF, 1'b0);
    send_byte(8'h03, 8'hFF, 1'b0);
    end_xfer();
    chk_int("b2b_overruns", ovr_cnt - o0, 2);
    // 8'h01 and 8'h02 were overwritten before anyone accepted them
    void'(rx_exp.pop_front());
    void'(rx_exp.pop_front());
    chk8("b2b_final_data", bus.rx_data, 8'h03);

    // Accept coinciding with completion of the next byte: no overrun
    start_xfer();
    o0 = ovr_cnt;
    send_byte(8'h04, 8'hFF, 1'b1);
    end_xfer();
    chk_int("coincident_accept_no_overrun", ovr_cnt - o0, 0);
    read_rx();

    // Abort after 4 sclk cycles (cpha=1), then a full byte
    set_mode(1'b0, 1'b1, 1'b0);
    start_xfer();
    spi_xfer(8'hF0, 4, 1'b0, mi);
    end_xfer();
    chk1("abort_no_rx_valid", bus.rx_valid, 1'b0);
    start_xfer();
    send_byte(8'h96, 8'hFF, 1'b0);
    end_xfer();
    read_rx();

    // cpha=0 abort before the first sample keeps the buffered byte
    set_mode(1'b0, 1'b0, 1'b0);
    preload(8'h55);
    start_xfer();
    repeat (3 * HP) @(negedge PCLK);
    end_xfer();
    chk1("abort_tx_still_full", bus.tx_ready, 1'b0);
    chk1("abort0_no_rx_valid", bus.rx_valid, 1'b0);
    start_xfer();
    send_byte(8'h2B, 8'h55, 1'b0);
    end_xfer();
    chk1("abort_buf_consumed", bus.tx_ready, 1'b1);
    read_rx();

    // Reset mid-byte with rx pending and tx buffer full
    set_mode(1'b0, 1'b0, 1'b0);
    start_xfer();
    send_byte(8'h5A, 8'hFF, 1'b0);
    end_xfer();
    preload(8'h99);
    start_xfer();
    spi_xfer(8'hA0, 4, 1'b0, mi);
    preload(8'h77);
    chk1("pre_reset_miso_oe", bus.miso_oe, 1'b1);
    chk1("pre_reset_rx_valid", bus.rx_valid, 1'b1);
    @(negedge PCLK);
    #1 PRESETn = 1'b0;
    #1 chk_reset_outputs("midbyte_reset");
    rx_exp.delete();
    miso_exp.delete();
    bus.ss    = 1'b1;
    bus.cpol  = 1'b1;
    bus.cpha  = 1'b1;
    bus.lsbfe = 1'b0;
    bus.sclk  = 1'b1;
    @(negedge PCLK);
    PRESETn = 1'b1;

    // Clean mode-3 transfer after reset
    set_mode(1'b1, 1'b1, 1'b0);
    start_xfer();
    send_byte(8'h7E, 8'hFF, 1'b0);
    end_xfer();
    chk1("post_reset_tx_ready", bus.tx_ready, 1'b1);
    read_rx();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_slave_endpoint.md
# spi_slave_endpoint

SPI slave endpoint that sits directly downstream of the SPI master controller: consumes its `sclk`/`ss`/`mosi` pins and returns `miso`. It oversamples the SPI pins in the `PCLK` domain, deserialises received bytes onto a valid/ready byte port, and serialises bytes supplied on a tx port. It serves as the on-chip loop-back target and bench partner for the controller; mode bits mirror the controller's `cpol`/`cpha`/`lsbfe`.

## Interface
- `TX_DEFAULT`, 8'hFF: byte shifted out when no tx byte is buffered at byte start.
- `PCLK` in 1: sole clock.
- `PRESETn` in 1: asynchronous active-low reset.
- `cpol` in 1: sclk idle level.
- `cpha` in 1: 0 = sample on leading edge; 1 = sample on trailing edge.
- `lsbfe` in 1: 1 = LSB first, 0 = MSB first.
- `sclk`, `ss`, `mosi` in 1 each: asynchronous SPI pins; `ss` active low.
- `miso` out 1: serial data to master.
- `miso_oe` out 1: high while `ss` is asserted (synchronised).
- `tx_data` in 8 / `tx_valid` in 1 / `tx_ready` out 1: tx byte handshake; transfer on `tx_valid && tx_ready`.
- `rx_data` out 8 / `rx_valid` out 1 / `rx_ready` in 1: rx byte handshake.
- `rx_overrun` out 1: one-cycle pulse.
- `tx_underrun` out 1: one-cycle pulse.

## Operation
- `sclk`, `ss` and `mosi` each pass through a 2-FF synchroniser; a third register on `sclk_s`/`ss_s` gives edge detection.
- Leading edge: rising if `cpol`=0, falling if `cpol`=1.
- Sample edge: leading if `cpha`=0, else trailing. The shift edge is the other edge.
- Edges are ignored while `ss_s`=1.
- `bit_cnt` (3-bit) and the shift register clear on the `ss_s` rising edge; any partial byte is discarded with no `rx_valid`.
- **TX buffer:** one-entry (`tx_full`); `tx_ready = !tx_full`.
- **Load:** the shift register loads `tx_buf` if `tx_full`, else `TX_DEFAULT`. Flag `from_buf` records the source; `tx_underrun` pulses when `TX_DEFAULT` is used. A load occurs:
  - on `ss_s` falling edge when `cpha`=0;
  - on any shift edge with `bit_cnt`=0, except the first trailing edge of a `cpha`=0 byte.
- **Pop:** `tx_full` clears on the first sample edge of a byte (`bit_cnt` 0→1), only if `from_buf`=1. A load that is aborted by `ss` deasserting therefore never consumes the buffer.
- **Shift:** on a shift edge with `bit_cnt`≠0, shift toward the output end. `miso` is the MSB when `lsbfe`=0 and the LSB when `lsbfe`=1.
- **Sample:** on each sample edge, shift `mosi_s` into the rx shift register from the opposite end to the output end, then `bit_cnt`++.
- **Byte complete:** when `bit_cnt` wraps 7→0, `rx_data` ← assembled byte and `rx_valid` ← 1. If `rx_valid` was already 1 and not accepted that cycle, the byte overwrites `rx_data` and `rx_overrun` pulses.
- `rx_valid` clears on `rx_valid && rx_ready` unless a new byte completes in the same cycle; in that case it stays 1 with the new data and there is no overrun.
- `miso` = 0 and `miso_oe` = 0 while `ss_s`=1.
- `cpol`, `cpha` and `lsbfe` must be static while `ss` is asserted; changes take effect at the next `ss` fall.

## Timing
- Reset values: `miso`=0, `miso_oe`=0, `tx_ready`=1, `rx_data`=8'h00, `rx_valid`=0, `rx_overrun`=0, `tx_underrun`=0; `bit_cnt`=0; synchroniser flops reset to `ss`=1, `sclk`=`cpol`-independent 0 (first-edge spurious detection is masked by `ss`).
- Pin edge to internal event: 3 `PCLK` cycles. `miso` updates 1 cycle after the event (4 cycles pin-to-pin).
- Requirements on the master:
  - each `sclk` phase lasts ≥ 5 `PCLK` cycles;
  - for `cpha`=0, `ss` falls ≥ 5 `PCLK` before the first `sclk` edge.
- `rx_valid` rises 1 cycle after the synchronised 8th sample edge.
- `tx_underrun` and `rx_overrun` are single-cycle pulses.
- Reset mid-byte returns every output and all state to reset values immediately (asynchronous).

## Test plan
- **Mode 0 receive:** `cpol`=0, `cpha`=0, `lsbfe`=0; master sends 8'hA5 with 5-PCLK sclk phases → `rx_data`=8'hA5, `rx_valid`=1 until `rx_ready`. `tx_buf` empty → `tx_underrun` pulses once; `miso` shows 8'hFF.
- **All four modes:** tx_data 8'h3C preloaded, `lsbfe`=1; master sends 8'hC3 → master receives 8'h3C, `rx_data`=8'hC3, `tx_ready` returns to 1 after the first sample edge.
- **Back-to-back:** three bytes 8'h01, 8'h02, 8'h03 without `ss` release, `rx_ready` held 0 → `rx_overrun` pulses twice, final `rx_data`=8'h03. Accept coinciding with the 3rd completion → no overrun on that byte.
- **Abort:** `ss` rises after 4 sclk cycles → no `rx_valid`, `bit_cnt` = 0. Next transfer returns correct full bytes. In `cpha`=0, `tx_buf` loaded with 8'h55 but `ss` rises before the first sample → `tx_full` remains 1 and 8'h55 is sent in the next transfer.
- **Reset:** assert `PRESETn` mid-byte → all outputs at reset values within the same cycle. After release, a clean mode-3 transfer of 8'h7E succeeds.
